// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard sequencing for the 5-stage core: load-use, branch redirect, memory wait
module pipeline_stall_ctrl #(
  parameter int BR_PENALTY = 2,
  parameter int MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_EX_memread,
  input  logic [2:0]  ID_EX_rd,
  input  logic [2:0]  rs1,
  input  logic [2:0]  rs2,
  input  logic        rs2_used,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_flush,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;

  localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);
  localparam logic [2:0] RED_INIT = 3'(BR_PENALTY - 1);

  state_t     st;
  logic [2:0] red_cnt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       hz;
  logic       ms;

  assign hz = ID_EX_memread && (ID_EX_rd != 3'd0) &&
              ((ID_EX_rd == rs1) || (rs2_used && (ID_EX_rd == rs2)));
  assign ms = mem_req && !mem_ready;
  // wait_cnt holds the length of the ms run ending last cycle; zero after any non-ms cycle
  assign wait_next = (wait_cnt >= MAX_W) ? MAX_W : wait_cnt + 8'd1;
  assign state = st;

  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (ms) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (st == REDIRECT) begin
      IF_ID_flush = 1'b1;
    end else if (branch_taken) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if (hz) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= RUN;
      red_cnt      <= 3'd0;
      wait_cnt     <= 8'd0;
      mem_timeout  <= 1'b0;
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (!pc_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (ms) begin
        wait_cnt <= wait_next;
        if (wait_next == MAX_W) mem_timeout <= 1'b1;
        // a hold inside a redirect freezes red_cnt and keeps the redirect pending
        if (st != REDIRECT) st <= MEM_WAIT;
      end else begin
        wait_cnt <= 8'd0;
        if (st == REDIRECT) begin
          red_cnt <= red_cnt - 3'd1;
          if (red_cnt == 3'd1) st <= RUN;
        end else if (branch_taken) begin
          if (flush_events != 16'hFFFF) flush_events <= flush_events + 16'd1;
          if (BR_PENALTY > 1) begin
            st      <= REDIRECT;
            red_cnt <= RED_INIT;
          end else begin
            st <= RUN;
          end
        end else begin
          st <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed bench with history-based reference model for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  localparam int BRP  = 2;
  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ID_EX_memread = 1'b0;
  logic [2:0]  ID_EX_rd = 3'd0;
  logic [2:0]  rs1 = 3'd0;
  logic [2:0]  rs2 = 3'd0;
  logic        rs2_used = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold, mem_timeout;
  logic [15:0] stall_cycles, flush_events;
  logic [1:0]  state;

  pipeline_stall_ctrl #(.BR_PENALTY(BRP), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .ID_EX_memread(ID_EX_memread), .ID_EX_rd(ID_EX_rd),
    .rs1(rs1), .rs2(rs2), .rs2_used(rs2_used), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_events(flush_events), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers how many flush cycles are still owed, the length of
  // the current memory-stall run and the event totals, and derives state from that history.
  int m_flush_left = 0;
  int m_ms_run     = 0;
  int m_stalls     = 0;
  int m_flushes    = 0;
  bit m_prev_ms    = 0;
  bit m_to         = 0;

  always @(negedge clk) begin
    bit hz_e, ms_e, e_pc, e_ifw, e_iff, e_idf, e_hold;
    int e_st;
    hz_e = 0; ms_e = 0; e_st = 0;
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
    if (rst) begin
      m_flush_left = 0; m_ms_run = 0; m_stalls = 0; m_flushes = 0;
      m_prev_ms = 0; m_to = 0;
      e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1;
    end else begin
      hz_e = ID_EX_memread && ID_EX_rd != 0 &&
             (ID_EX_rd == rs1 || (rs2_used && ID_EX_rd == rs2));
      ms_e = mem_req && !mem_ready;
      e_st = (m_flush_left > 0) ? 2 : (m_prev_ms ? 1 : 0);
      if (ms_e) begin
        e_pc = 0; e_ifw = 0; e_hold = 1;
      end else if (m_flush_left > 0) begin
        e_iff = 1;
      end else if (branch_taken) begin
        e_iff = 1; e_idf = 1;
      end else if (hz_e) begin
        e_pc = 0; e_ifw = 0; e_idf = 1;
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("IF_ID_write", IF_ID_write, e_ifw);
    chk("IF_ID_flush", IF_ID_flush, e_iff);
    chk("ID_EX_flush", ID_EX_flush, e_idf);
    chk("pipe_hold", pipe_hold, e_hold);
    chk("state", state, e_st);
    chk("mem_timeout", mem_timeout, m_to);
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("flush_events", flush_events, m_flushes);
    if (!rst) begin
      if (!e_pc && m_stalls < 65535) m_stalls++;
      if (ms_e) begin
        m_prev_ms = 1;
        if (m_ms_run < MAXW) m_ms_run++;
        if (m_ms_run >= MAXW) m_to = 1;
      end else begin
        m_prev_ms = 0;
        m_ms_run  = 0;
        if (m_flush_left > 0) m_flush_left--;
        else if (branch_taken) begin
          if (m_flushes < 65535) m_flushes++;
          m_flush_left = BRP - 1;
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic clear;
    ID_EX_memread = 0; ID_EX_rd = 0; rs1 = 0; rs2 = 0; rs2_used = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    repeat (3) begin
      nxt;
      ID_EX_memread = 1'($urandom); ID_EX_rd = 3'($urandom); rs1 = 3'($urandom);
      rs2 = 3'($urandom); rs2_used = 1'($urandom); branch_taken = 1'($urandom);
      mem_req = 1'($urandom); mem_ready = 1'($urandom);
      smp;
      chk("rst_pc", pc_write, 0);
      chk("rst_iff", IF_ID_flush, 1);
      chk("rst_idf", ID_EX_flush, 1);
      chk("rst_state", state, 0);
      chk("rst_stalls", stall_cycles, 0);
    end
    nxt; rst = 0; clear; smp;
    chk("rel_pc", pc_write, 1);
    chk("rel_ifw", IF_ID_write, 1);

    nxt; ID_EX_memread = 1; ID_EX_rd = 3; rs1 = 3; smp;
    chk("lu_pc", pc_write, 0);
    chk("lu_idf", ID_EX_flush, 1);
    nxt; ID_EX_memread = 0; smp;
    chk("lu_after_pc", pc_write, 1);
    chk("lu_stalls", stall_cycles, 1);
    nxt; ID_EX_memread = 1; ID_EX_rd = 0; rs1 = 0; smp;
    chk("rd0_pc", pc_write, 1);
    nxt; ID_EX_rd = 3; rs1 = 1; rs2 = 3; rs2_used = 0; smp;
    chk("rs2_unused_pc", pc_write, 1);
    nxt; rs2_used = 1; smp;
    chk("rs2_used_pc", pc_write, 0);
    nxt; clear; smp;
    chk("lu_stalls2", stall_cycles, 2);

    nxt; branch_taken = 1; smp;
    chk("br0_iff", IF_ID_flush, 1);
    chk("br0_idf", ID_EX_flush, 1);
    chk("br0_pc", pc_write, 1);
    nxt; branch_taken = 0; smp;
    chk("br1_iff", IF_ID_flush, 1);
    chk("br1_idf", ID_EX_flush, 0);
    chk("br1_state", state, 2);
    nxt; smp;
    chk("br2_state", state, 0);
    chk("br2_iff", IF_ID_flush, 0);
    chk("br_flushes", flush_events, 1);

    nxt; branch_taken = 1; ID_EX_memread = 1; ID_EX_rd = 3; rs1 = 3; smp;
    chk("brhz_pc", pc_write, 1);
    nxt; branch_taken = 0; smp;
    chk("redir_hz_pc", pc_write, 1);
    chk("redir_hz_state", state, 2);
    nxt; clear; smp;
    chk("brhz_flushes", flush_events, 2);

    nxt; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt;
      smp;
      chk("mw_hold", pipe_hold, 1);
    end
    nxt; mem_ready = 1; smp;
    chk("mw_release_hold", pipe_hold, 0);
    chk("mw_release_pc", pc_write, 1);
    chk("mw_stalls", stall_cycles, 6);
    chk("mw_timeout", mem_timeout, 0);
    nxt; clear;

    nxt; mem_req = 1; mem_ready = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) nxt;
      smp;
      if (i == 15) chk("to_before", mem_timeout, 0);
      if (i == 16) chk("to_after", mem_timeout, 1);
    end
    nxt; clear; smp;
    chk("to_sticky", mem_timeout, 1);
    chk("to_stalls", stall_cycles, 26);

    nxt; branch_taken = 1; smp;
    nxt; branch_taken = 0; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) nxt;
      smp;
      chk("rms_state", state, 2);
      chk("rms_hold", pipe_hold, 1);
    end
    nxt; mem_req = 0; smp;
    chk("rms_flush", IF_ID_flush, 1);
    chk("rms_flush_state", state, 2);
    nxt; smp;
    chk("rms_done_state", state, 0);
    chk("rms_flushes", flush_events, 3);
    chk("rms_stalls", stall_cycles, 29);

    nxt; branch_taken = 1; smp;
    nxt; branch_taken = 0; smp;
    chk("mid_state", state, 2);
    nxt; #2 rst = 1; #1;
    chk("abort_state", state, 0);
    chk("abort_iff", IF_ID_flush, 1);
    chk("abort_stalls", stall_cycles, 0);
    chk("abort_flushes", flush_events, 0);
    chk("abort_to", mem_timeout, 0);
    smp;
    nxt; rst = 0;
    repeat (2) nxt;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
